// File: rtl/uart_bootloader.sv
// Serial boot loader: parses the A5/5A framed download stream from the UART receiver,
// writes payload words to memory as a bus master and holds the CPU in reset while loading.
module uart_bootloader #(
  parameter int unsigned TIMEOUT_CYCLES = 6250000,
  parameter bit          HOLD_AT_RESET  = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rxnew,
  input  logic [7:0]  rxdata,
  output logic [31:0] a,
  output logic [31:0] d,
  output logic        we,
  input  logic        ready,
  output logic        cpu_rst,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code
);

  typedef enum logic [2:0] {
    SYNC0, SYNC1, ADDR, LEN, DATA, SUM, DRAIN
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_SUM      = 2'b01,
    ERR_TIMEOUT  = 2'b10,
    ERR_OVERRUN  = 2'b11
  } err_t;

  // idle_cnt reads k-1 in the k-th cycle after the last byte, so comparing against
  // TIMEOUT_CYCLES-2 makes the abort visible exactly TIMEOUT_CYCLES cycles after that byte.
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 2);

  state_t      state;
  logic [31:0] waddr;
  logic [15:0] word_cnt;
  logic [1:0]  byte_idx;
  logic [23:0] shift;
  logic [7:0]  sum;
  logic [31:0] idle_cnt;

  logic write_done;
  logic buf_free;
  logic timeout;

  assign write_done = we && ready;
  // A write retiring this cycle frees the single buffer entry for a word completing now.
  assign buf_free   = !we || ready;
  assign timeout    = (state != SYNC0) && !rxnew && (idle_cnt == TIMEOUT_LAST);
  assign busy       = (state != SYNC0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: reset is synchronous and active-low; it also wins over rxnew so bytes
      // arriving during reset are dropped.
      state    <= SYNC0;
      a        <= '0;
      d        <= '0;
      we       <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      err_code <= ERR_NONE;
      cpu_rst  <= HOLD_AT_RESET;
      waddr    <= '0;
      word_cnt <= '0;
      byte_idx <= '0;
      shift    <= '0;
      sum      <= '0;
      idle_cnt <= '0;
    end else begin
      // NOTE: all state here uses non-blocking assignments; later assignments in this
      // block deliberately override the defaults just below (e.g. a new word reloads we).
      done <= 1'b0;
      if (write_done) we <= 1'b0;

      if (rxnew || state == SYNC0) idle_cnt <= '0;
      else                         idle_cnt <= idle_cnt + 32'd1;

      if (timeout) begin
        err      <= 1'b1;
        err_code <= ERR_TIMEOUT;
        cpu_rst  <= 1'b0;
        state    <= SYNC0;
      end else if (state == DRAIN) begin
        if (!we) begin
          done    <= 1'b1;
          cpu_rst <= 1'b0;
          state   <= SYNC0;
        end
      end else if (rxnew) begin
        case (state)
          SYNC0: begin
            if (rxdata == 8'hA5) state <= SYNC1;
          end
          SYNC1: begin
            if (rxdata == 8'h5A) begin
              state    <= ADDR;
              cpu_rst  <= 1'b1;
              err      <= 1'b0;
              err_code <= ERR_NONE;
              byte_idx <= '0;
              sum      <= '0;
            end else if (rxdata != 8'hA5) begin
              state <= SYNC0;
            end
          end
          ADDR: begin
            waddr    <= {waddr[23:0], rxdata};
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) state <= LEN;
          end
          LEN: begin
            word_cnt <= {word_cnt[7:0], rxdata};
            if (byte_idx == 2'd1) begin
              byte_idx <= '0;
              state    <= ({word_cnt[7:0], rxdata} == 16'd0) ? SUM : DATA;
            end else begin
              byte_idx <= byte_idx + 2'd1;
            end
          end
          DATA: begin
            sum      <= sum + rxdata;
            shift    <= {shift[15:0], rxdata};
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              if (buf_free) begin
                a        <= waddr;
                d        <= {shift, rxdata};
                we       <= 1'b1;
                waddr    <= waddr + 32'd4;
                word_cnt <= word_cnt - 16'd1;
                if (word_cnt == 16'd1) state <= SUM;
              end else begin
                err      <= 1'b1;
                err_code <= ERR_OVERRUN;
                cpu_rst  <= 1'b0;
                state    <= SYNC0;
              end
            end
          end
          SUM: begin
            if (rxdata == sum) begin
              state <= DRAIN;
            end else begin
              err      <= 1'b1;
              err_code <= ERR_SUM;
              cpu_rst  <= 1'b0;
              state    <= SYNC0;
            end
          end
          default: state <= SYNC0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_bootloader.sv
// Directed bench for uart_bootloader: full frame, bad checksum, timeout, resync/LEN=0,
// overrun with a stalled bus, and reset in mid-frame.
module tb_uart_bootloader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rxnew = 1'b0;
  logic [7:0]  rxdata = 8'h00;
  logic [31:0] a;
  logic [31:0] d;
  logic        we;
  logic        ready = 1'b1;
  logic        cpu_rst;
  logic        busy;
  logic        done;
  logic        err;
  logic [1:0]  err_code;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int done_base;
  logic [63:0] wr_q[$];
  logic [7:0]  model_sum;

  uart_bootloader #(.TIMEOUT_CYCLES(100), .HOLD_AT_RESET(1'b0)) dut (
    .clk(clk), .rst(rst), .rxnew(rxnew), .rxdata(rxdata),
    .a(a), .d(d), .we(we), .ready(ready),
    .cpu_rst(cpu_rst), .busy(busy), .done(done), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst && we && ready) wr_q.push_back({a, d});
    if (done) done_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_write(input string tag, input logic [31:0] ea, input logic [31:0] ed);
    logic [63:0] got;
    got = (wr_q.size() > 0) ? wr_q.pop_front() : 64'hFFFF_FFFF_FFFF_FFFF;
    check(tag, got, {ea, ed});
  endtask

  // Pulses rxnew for one cycle; returns #1 after the edge that consumed the byte.
  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rxnew  = 1'b1;
    rxdata = b;
    @(posedge clk); #1;
    rxnew  = 1'b0;
  endtask

  task automatic send_header(input logic [31:0] addr, input logic [15:0] len);
    send_byte(8'hA5);
    send_byte(8'h5A);
    for (int i = 3; i >= 0; i--) send_byte(addr[8*i +: 8]);
    send_byte(len[15:8]);
    send_byte(len[7:0]);
    model_sum = 8'h00;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) begin
      send_byte(w[8*i +: 8]);
      model_sum = model_sum + w[8*i +: 8];
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    cycles(3);
    check("rst_a", a, 0);
    check("rst_d", d, 0);
    check("rst_we", we, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_code", err_code, 0);
    check("rst_cpu_rst", cpu_rst, 0);
    rst = 1'b1;
    cycles(2);

    // Full frame, ready tied high.
    done_base = done_cnt;
    send_header(32'h0000_1000, 16'd2);
    check("full_cpu_rst_hi", cpu_rst, 1);
    check("full_busy", busy, 1);
    send_word(32'hDEAD_BEEF);
    check("full_we_t1", we, 1);
    check("full_a_t1", a, 32'h1000);
    check("full_d_t1", d, 32'hDEAD_BEEF);
    send_word(32'h0102_0304);
    send_byte(model_sum);
    check("full_done_t1", done, 0);
    cycles(1);
    check("full_done_t2", done, 1);
    check("full_cpu_rst_lo", cpu_rst, 0);
    check("full_busy_end", busy, 0);
    check("full_err", err, 0);
    cycles(1);
    check("full_done_pulse", done, 0);
    check("full_nwr", wr_q.size(), 2);
    check_write("full_wr0", 32'h1000, 32'hDEAD_BEEF);
    check_write("full_wr1", 32'h1004, 32'h0102_0304);
    check("full_ndone", done_cnt - done_base, 1);

    // Same frame with a wrong checksum byte.
    done_base = done_cnt;
    send_header(32'h0000_1000, 16'd2);
    send_word(32'hDEAD_BEEF);
    send_word(32'h0102_0304);
    send_byte(model_sum + 8'd1);
    check("bad_err", err, 1);
    check("bad_code", err_code, 2'b01);
    check("bad_cpu_rst", cpu_rst, 0);
    check("bad_busy", busy, 0);
    cycles(4);
    check("bad_ndone", done_cnt - done_base, 0);
    check("bad_nwr", wr_q.size(), 2);
    check_write("bad_wr0", 32'h1000, 32'hDEAD_BEEF);
    check_write("bad_wr1", 32'h1004, 32'h0102_0304);

    // Timeout: abort lands 100 cycles after the last byte.
    send_byte(8'hA5);
    send_byte(8'h5A);
    send_byte(8'h00);
    send_byte(8'h00);
    cycles(98);
    check("to_busy_t99", busy, 1);
    check("to_err_t99", err, 0);
    cycles(1);
    check("to_code_t100", err_code, 2'b10);
    check("to_err_t100", err, 1);
    check("to_busy_t100", busy, 0);
    check("to_cpu_rst", cpu_rst, 0);

    // Resync on garbage and a repeated A5, then an empty payload.
    done_base = done_cnt;
    send_byte(8'h33);
    send_byte(8'hA5);
    send_byte(8'hA5);
    send_byte(8'h5A);
    check("rs_err_clr", err, 0);
    check("rs_code_clr", err_code, 0);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h20);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    cycles(1);
    check("rs_done", done, 1);
    cycles(2);
    check("rs_ndone", done_cnt - done_base, 1);
    check("rs_nwr", wr_q.size(), 0);
    check("rs_err", err, 0);

    // Overrun: bus stalled, second word completes while the first is pending.
    ready = 1'b0;
    send_header(32'h0000_3000, 16'd2);
    send_word(32'h1122_3344);
    check("ov_we", we, 1);
    check("ov_a", a, 32'h3000);
    send_byte(8'h55);
    send_byte(8'h66);
    send_byte(8'h77);
    check("ov_err_b7", err, 0);
    send_byte(8'h88);
    check("ov_code", err_code, 2'b11);
    check("ov_err", err, 1);
    check("ov_busy", busy, 0);
    check("ov_d_held", d, 32'h1122_3344);
    cycles(3);
    check("ov_we_held", we, 1);
    check("ov_a_held", a, 32'h3000);
    ready = 1'b1;
    cycles(1);
    check("ov_we_drop", we, 0);
    check("ov_nwr", wr_q.size(), 1);
    check_write("ov_wr0", 32'h3000, 32'h1122_3344);

    // Reset in mid-frame, with a byte arriving during reset.
    send_header(32'h0000_4000, 16'd1);
    check("mr_busy_pre", busy, 1);
    rst    = 1'b0;
    rxnew  = 1'b1;
    rxdata = 8'hCA;
    cycles(1);
    rxnew  = 1'b0;
    cycles(1);
    check("mr_a", a, 0);
    check("mr_d", d, 0);
    check("mr_we", we, 0);
    check("mr_busy", busy, 0);
    check("mr_err", err, 0);
    check("mr_code", err_code, 0);
    check("mr_cpu_rst", cpu_rst, 0);
    rst = 1'b1;
    cycles(2);
    check("mr_nwr", wr_q.size(), 0);
    done_base = done_cnt;
    send_header(32'h0000_4000, 16'd1);
    send_word(32'hCAFE_F00D);
    send_byte(model_sum);
    cycles(3);
    check("mr_ndone", done_cnt - done_base, 1);
    check("mr_err_after", err, 0);
    check("mr_nwr_after", wr_q.size(), 1);
    check_write("mr_wr0", 32'h4000, 32'hCAFE_F00D);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
